// File: rtl/input_conditioner_if.sv
// Button/frame bundle between the raw player controls, the video timing block
// and the game logic. The master side drives raw buttons and vsync; the
// slave side (the conditioner) returns the per-frame button snapshots.
interface input_conditioner_if #(
  parameter int NUM_BUTTONS = 5
);
  logic [NUM_BUTTONS-1:0] p1_inputs_n;
  logic [NUM_BUTTONS-1:0] p2_inputs_n;
  logic                   vsync;
  logic                   frame_tick;
  logic [NUM_BUTTONS-1:0] p1_held;
  logic [NUM_BUTTONS-1:0] p2_held;
  logic [NUM_BUTTONS-1:0] p1_pressed;
  logic [NUM_BUTTONS-1:0] p2_pressed;

  modport master (
    output p1_inputs_n, p2_inputs_n, vsync,
    input  frame_tick, p1_held, p2_held, p1_pressed, p2_pressed
  );

  modport slave (
    input  p1_inputs_n, p2_inputs_n, vsync,
    output frame_tick, p1_held, p2_held, p1_pressed, p2_pressed
  );
endinterface

// File: rtl/input_conditioner.sv
// Player button conditioner: 2-flop synchroniser and counter debounce per
// button, then a once-per-frame snapshot on the vsync falling edge giving
// active-high held levels and one-frame new-press flags. Both players share
// one datapath vector: bits [NUM_BUTTONS-1:0] are player 1, the upper half
// player 2; no bit ever influences another.
module input_conditioner #(
  parameter int NUM_BUTTONS     = 5,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_WIDTH       = 18
) (
  input  logic                clk,
  input  logic                reset,
  input_conditioner_if.slave  bus
);

  localparam int NB2 = 2 * NUM_BUTTONS;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

  logic [NB2-1:0]       raw_s;
  logic [NB2-1:0]       sync1_q;
  logic [NB2-1:0]       sync2_q;
  logic [NB2-1:0]       btn_s;
  logic [NB2-1:0]       deb_q;
  logic [NB2-1:0]       deb_d;
  logic [CNT_WIDTH-1:0] cnt_q [NB2];
  logic [CNT_WIDTH-1:0] cnt_d [NB2];
  logic                 vsync_q;
  logic                 fall_s;
  logic                 frame_tick_q;
  logic [NB2-1:0]       held_q;
  logic [NB2-1:0]       held_d;
  logic [NB2-1:0]       pressed_q;
  logic [NB2-1:0]       pressed_d;

  assign raw_s  = {bus.p2_inputs_n, bus.p1_inputs_n};
  // Flop 2 output is still active-low; invert so 1 means pressed.
  assign btn_s  = ~sync2_q;
  assign fall_s = vsync_q & ~bus.vsync;

  // Two-stage synchroniser for the asynchronous button pins; idles released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= {NB2{1'b1}};
      sync2_q <= {NB2{1'b1}};
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next state: a level must disagree with the stable value for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NB2; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (btn_s[i] == deb_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = btn_s[i];
        cnt_d[i] = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Debounce state and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q <= {NB2{1'b0}};
      for (int i = 0; i < NB2; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < NB2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Snapshot next state: on a vsync fall capture the pre-edge debounced
  // levels and flag buttons that were not held in the previous snapshot.
  always_comb begin
    held_d    = held_q;
    pressed_d = pressed_q;
    if (fall_s) begin
      held_d    = deb_q;
      pressed_d = deb_q & ~held_q;
    end else begin
      held_d    = held_q;
      pressed_d = pressed_q;
    end
  end

  // Frame edge detection and registered snapshot outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
      held_q       <= {NB2{1'b0}};
      pressed_q    <= {NB2{1'b0}};
    end else begin
      vsync_q      <= bus.vsync;
      frame_tick_q <= fall_s;
      held_q       <= held_d;
      pressed_q    <= pressed_d;
    end
  end

  assign bus.frame_tick = frame_tick_q;
  assign bus.p1_held    = held_q[NUM_BUTTONS-1:0];
  assign bus.p2_held    = held_q[NB2-1:NUM_BUTTONS];
  assign bus.p1_pressed = pressed_q[NUM_BUTTONS-1:0];
  assign bus.p2_pressed = pressed_q[NB2-1:NUM_BUTTONS];

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4 and a 40-cycle frame
// (vsync low 2 cycles). A window-based reference model is compared against
// the DUT on every falling clock edge; directed steps add literal checks.
module tb_input_conditioner;

  localparam int NB  = 5;
  localparam int NB2 = 2 * NB;
  localparam int DEB = 4;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vcnt     = 0;

  input_conditioner_if #(.NUM_BUTTONS(NB)) bus ();

  input_conditioner #(
    .NUM_BUTTONS(NB),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH(18)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Reference model state: last DEB+2 pin samples per button, debounced level,
  // snapshot registers and previous vsync.
  logic           pin_h [NB2][DEB+2];
  logic [NB2-1:0] d_m;
  logic [NB2-1:0] held_m;
  logic [NB2-1:0] pressed_m;
  logic           tick_m;
  logic           vprev_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < NB2; b++)
      for (int k = 0; k < DEB + 2; k++) pin_h[b][k] = 1'b1;
    d_m = '0; held_m = '0; pressed_m = '0; tick_m = 1'b0; vprev_m = 1'b1;
  endtask

  // A button's accepted level flips once the synchronised samples (pins seen
  // two edges ago and older) have disagreed with it for DEB edges in a row.
  task automatic model_step();
    logic [NB2-1:0] raw;
    logic           all_differ;
    raw = {bus.p2_inputs_n, bus.p1_inputs_n};
    tick_m = vprev_m & ~bus.vsync;
    if (tick_m) begin
      pressed_m = d_m & ~held_m;
      held_m    = d_m;
    end
    vprev_m = bus.vsync;
    for (int b = 0; b < NB2; b++) begin
      for (int k = DEB + 1; k > 0; k--) pin_h[b][k] = pin_h[b][k-1];
      pin_h[b][0] = raw[b];
      all_differ = 1'b1;
      for (int k = 2; k <= DEB + 1; k++)
        if (!pin_h[b][k] == d_m[b]) all_differ = 1'b0;
      if (all_differ) d_m[b] = !pin_h[b][2];
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // vsync: low for 2 of every 40 cycles, changing on falling edges.
  initial begin
    bus.vsync = 1'b1;
    forever begin
      @(negedge clk);
      vcnt = (vcnt + 1) % 40;
      bus.vsync = (vcnt >= 38) ? 1'b0 : 1'b1;
    end
  end

  // Model update on every clock edge, cleared asynchronously by reset.
  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_clear();
      else model_step();
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("frame_tick", 32'(bus.frame_tick), 32'(tick_m));
      chk("p1_held",    32'(bus.p1_held),    32'(held_m[NB-1:0]));
      chk("p2_held",    32'(bus.p2_held),    32'(held_m[NB2-1:NB]));
      chk("p1_pressed", 32'(bus.p1_pressed), 32'(pressed_m[NB-1:0]));
      chk("p2_pressed", 32'(bus.p2_pressed), 32'(pressed_m[NB2-1:NB]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_tick();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.frame_tick) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_tick: no frame_tick within 60 cycles at %0t", $time);
  endtask

  initial begin
    int ticks;
    int k_dut;
    int k_mod;
    reset = 1'b1;
    bus.p1_inputs_n = {NB{1'b1}};
    bus.p2_inputs_n = {NB{1'b1}};
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_p1_held",    32'(bus.p1_held),    32'd0);
    chk("rst_p2_pressed", 32'(bus.p2_pressed), 32'd0);
    chk("rst_tick",       32'(bus.frame_tick), 32'd0);
    reset = 1'b1;

    // Idle: exactly one tick per 40 cycles.
    ticks = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.frame_tick) ticks++;
    end
    chk("tick_rate", 32'(ticks), 32'd2);

    // Single press: debounce latency 6 edges, pressed for one frame only.
    wait_tick();
    bus.p1_inputs_n[0] = 1'b0;
    k_dut = 0; k_mod = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k_dut == 0 && dut.deb_q[0]) k_dut = k;
      if (k_mod == 0 && d_m[0]) k_mod = k;
    end
    chk("latency_dut",   32'(k_dut), 32'd6);
    chk("latency_model", 32'(k_mod), 32'd6);
    wait_tick();
    chk("press_held",    32'(bus.p1_held),    32'h01);
    chk("press_pressed", 32'(bus.p1_pressed), 32'h01);
    wait_tick();
    chk("hold_held",     32'(bus.p1_held),    32'h01);
    chk("hold_pressed",  32'(bus.p1_pressed), 32'h00);
    bus.p1_inputs_n[0] = 1'b1;
    wait_tick();
    chk("release_held",  32'(bus.p1_held),    32'h00);

    // Glitches of 3 cycles never get through the debounce.
    ticks = 0;
    for (int c = 0; c < 125; c++) begin
      bus.p2_inputs_n[3] = ((c % 5) < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (bus.frame_tick) begin
        ticks++;
        chk("glitch_held",    32'(bus.p2_held),    32'h00);
        chk("glitch_pressed", 32'(bus.p2_pressed), 32'h00);
      end
    end
    bus.p2_inputs_n[3] = 1'b1;
    chk("glitch_ticks", 32'(ticks), 32'd3);

    // Simultaneous presses on both players.
    wait_tick();
    bus.p1_inputs_n[2] = 1'b0;
    bus.p2_inputs_n[4] = 1'b0;
    wait_tick();
    chk("both_p1_pressed", 32'(bus.p1_pressed), 32'h04);
    chk("both_p2_pressed", 32'(bus.p2_pressed), 32'h10);
    bus.p1_inputs_n[2] = 1'b1;
    bus.p2_inputs_n[4] = 1'b1;
    wait_tick();
    chk("both_rel_p1_held",    32'(bus.p1_held),    32'h00);
    chk("both_rel_p2_held",    32'(bus.p2_held),    32'h00);
    chk("both_rel_p1_pressed", 32'(bus.p1_pressed), 32'h00);
    chk("both_rel_p2_pressed", 32'(bus.p2_pressed), 32'h00);

    // Debounce completing on the snapshot edge is seen one frame later.
    wait_tick();
    repeat (34) @(negedge clk);
    bus.p1_inputs_n[1] = 1'b0;
    wait_tick();
    chk("edge_old_held",    32'(bus.p1_held),    32'h00);
    chk("edge_old_pressed", 32'(bus.p1_pressed), 32'h00);
    chk("edge_model_d",     32'(d_m[1]),         32'd1);
    wait_tick();
    chk("edge_new_held",    32'(bus.p1_held),    32'h02);
    chk("edge_new_pressed", 32'(bus.p1_pressed), 32'h02);

    // Mid-frame reset while a button is held.
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_held", 32'(bus.p1_held),    32'h00);
    chk("async_rst_tick", 32'(bus.frame_tick), 32'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_tick();
    chk("post_rst_held",    32'(bus.p1_held),    32'h02);
    chk("post_rst_pressed", 32'(bus.p1_pressed), 32'h02);
    wait_tick();
    chk("post_rst_pressed2", 32'(bus.p1_pressed), 32'h00);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Sits directly upstream of the game logic. Conditions the raw player buttons before game logic sees them.
- Per button: synchronises the raw active-low input to the pixel clock, then debounces it.
- Once per video frame, on the falling edge of vsync, it snapshots the debounced buttons. Game logic gets active-high "held" levels plus one-frame "pressed" (new-press) flags.
- This replaces the bare inversion currently applied to p1_inputs/p2_inputs.

Parameters:
- NUM_BUTTONS, 5, buttons per player.
- DEBOUNCE_CYCLES, 250000, consecutive clk cycles a new level must persist before it is accepted (10 ms at 25 MHz). Legal range 2 to 2^CNT_WIDTH-1.
- CNT_WIDTH, 18, width of each per-button debounce counter.

Ports:
- clk, input, 1, pixel clock (PLL output).
- reset, input, 1, asynchronous active-low reset (PLL-lock-qualified reset).
- p1_inputs_n, input, NUM_BUTTONS, raw player-1 buttons, asynchronous, 0 = pressed.
- p2_inputs_n, input, NUM_BUTTONS, raw player-2 buttons, asynchronous, 0 = pressed.
- vsync, input, 1, active-low vertical sync from the VGA timing block, synchronous to clk.
- frame_tick, output, 1, one-cycle pulse marking the snapshot cycle.
- p1_held, output, NUM_BUTTONS, player-1 debounced level snapshot, 1 = pressed.
- p2_held, output, NUM_BUTTONS, player-2 debounced level snapshot, 1 = pressed.
- p1_pressed, output, NUM_BUTTONS, player-1 rising-edge flags for the current frame.
- p2_pressed, output, NUM_BUTTONS, player-2 rising-edge flags for the current frame.

Behaviour:
- Reset: while reset=0, all state clears asynchronously.
  - Synchroniser flops reset to 1 (released).
  - Debounced state reset to 0 (released); counters reset to 0.
  - vsync delay flop resets to 1.
  - All outputs reset to 0.
- Reset may assert mid-debounce or mid-frame. No partial state survives. The first snapshot after release reports only buttons whose debounce has completed since release.
- Synchroniser: 2-flop chain per bit; s = inverted output of flop 2, so s is active-high.
- Debounce, per bit, with stable register d and counter c:
  - s == d: c <= 0.
  - s != d and c < DEBOUNCE_CYCLES-1: c <= c+1.
  - s != d and c == DEBOUNCE_CYCLES-1: d <= s, c <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes d; any return to s == d restarts the count from 0.
  - Latency from a clean pin change to d changing is exactly DEBOUNCE_CYCLES+2 clk edges. Press and release are symmetric.
- Frame detect:
  - vsync_d <= vsync each cycle.
  - fall = vsync_d & ~vsync.
  - On the clk edge after the cycle where fall=1, frame_tick=1 for exactly one cycle.
- Snapshot, on that same edge, for each player:
  - held <= d.
  - pressed <= d & ~held_previous.
  - held/pressed stay constant until the next snapshot. pressed is therefore valid for a whole frame and is never set in two consecutive frames for one continuous press.
  - Debounce transitions between snapshots are not buffered: a press-and-release inside one frame is lost. This is the accepted behaviour.
  - If d changes on the snapshot edge itself, the snapshot takes the pre-change d value.
- Both players are processed independently and identically; no cross-player interaction.
- Game logic clocked on ~vsync sees the snapshot of the previous frame. A one-frame input latency is by design.
- Counter arithmetic is unsigned; c never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.

Test Plan (DEBOUNCE_CYCLES=4, vsync low 2 cycles every 40 cycles):
- Reset, then hold all inputs 1 -> all outputs 0. frame_tick pulses once per 40 cycles, one cycle after each vsync falling edge.
- p1_inputs_n[0]=0 held steady -> internal d[0] rises exactly 6 edges after the pin change. The next frame_tick gives p1_held=5'b00001, p1_pressed=5'b00001. The following frame gives p1_pressed=0 with p1_held still 5'b00001.
- p2_inputs_n[3] low for 3 cycles then high, repeated with 2-cycle gaps -> p2_held and p2_pressed stay 0 across 3 frames.
- p1 button 2 pressed and p2 button 4 pressed simultaneously -> same frame_tick gives p1_pressed=5'b00100 and p2_pressed=5'b10000. Release both -> held returns to 0 one frame after debounce completes, with pressed=0.
- Debounce completes on the snapshot edge itself -> that snapshot shows old d. The next frame shows held=1, pressed=1.
- Assert reset mid-frame while buttons are held -> outputs go 0 immediately (asynchronous). After release, pressed=1 only on the first snapshot taken at least 6 cycles after release.
